// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: output polarities, blank code and hex font.
// Segment bytes are ordered {DP,G,F,E,D,C,B,A}, all active-low.
package seg_pkg;

  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;
  localparam logic AN_ON   = 1'b0;
  localparam logic AN_OFF  = 1'b1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Glyphs 0-9, A, b, C, d, E, F with the DP bit left dark.
  localparam logic [7:0] HEX_FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] hex_glyph(input logic [3:0] value);
    return HEX_FONT[value];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-segment decoder: 4-bit value plus decimal point request to an
// active-low {DP,G,F,E,D,C,B,A} cathode pattern.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = hex_glyph(value);
    if (dp) seg[7] = SEG_ON;
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment scanner with per-digit decimal point and optional blinking.
// Blinking is compiled in only when SEG_SCANNER_BLINK_EN is defined.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(REFRESH_DIV);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PS_W-1:0]       ps;
  logic [IDX_W-1:0]      idx;
  logic                  slot_tick;
  logic                  wrap;
  logic                  blink_ph;

  logic [3:0]            sel_val;
  logic                  sel_dp;
  logic                  sel_mask;
  logic [NUM_DIGITS-1:0] an_next;
  logic [7:0]            dec_seg;

  assign slot_tick = en && (ps == PS_LAST);
  assign wrap      = slot_tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= '0;
    end else if (en) begin
      ps <= (ps == PS_LAST) ? '0 : ps + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (slot_tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= wrap;
  end

`ifdef SEG_SCANNER_BLINK_EN
  localparam int BL_W = $clog2(BLINK_DIV);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  logic [BL_W-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (en) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  // Without blinking the phase is stuck low, so blink_mask has no effect.
  assign blink_ph = 1'b0;
`endif

  always_comb begin
    sel_val  = 4'h0;
    sel_dp   = 1'b0;
    sel_mask = 1'b0;
    an_next  = {NUM_DIGITS{AN_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_val    = digits[4*i +: 4];
        sel_dp     = dp[i];
        sel_mask   = blink_mask[i];
        an_next[i] = AN_ON;
      end
    end
  end

  seg_hex_decoder u_dec (
    .value (sel_val),
    .dp    (sel_dp),
    .seg   (dec_seg)
  );

  // Outputs are registered; a blanked digit still drives its anode.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      an  <= {NUM_DIGITS{AN_OFF}};
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= (blink_ph && sel_mask) ? SEG_BLANK : dec_seg;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: directed scans with a queue-based scoreboard.
// Covers both builds of SEG_SCANNER_BLINK_EN; a second single-digit instance is checked too.
module tb_seg_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  logic [3:0]  digits2;
  logic        dp2;
  logic        blink_mask2;
  logic        an2;
  logic [7:0]  seg2;
  logic        frame_tick2;

  seg_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .dp         (dp),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  seg_display_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(2), .BLINK_DIV(4)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits2),
    .dp         (dp2),
    .blink_mask (blink_mask2),
    .an         (an2),
    .seg        (seg2),
    .frame_tick (frame_tick2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         chk;
    logic [3:0] an;
    logic [7:0] seg;
    bit         ft;
    bit         chk2;
    logic       an2;
    logic [7:0] seg2;
    bit         ft2;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [3:0] AN_TAB   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [7:0] SEG_1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
  localparam logic [7:0] SEG_ABCD [4] = '{8'hA1, 8'hC6, 8'h03, 8'h88};

  function automatic exp_t mk(input logic [3:0] a, input logic [7:0] s, input bit f,
                              input string n);
    exp_t e;
    e.chk  = 1'b1;
    e.an   = a;
    e.seg  = s;
    e.ft   = f;
    e.chk2 = 1'b0;
    e.an2  = 1'b1;
    e.seg2 = 8'hFF;
    e.ft2  = 1'b0;
    e.name = n;
    return e;
  endfunction

  task automatic step(input exp_t e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cmp(input string n, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", n, $time, act, req);
    end
  endtask

  // Monitor: one expectation per clock, compared just after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          cmp({e.name, ".an"},  {4'h0, an},         {4'h0, e.an});
          cmp({e.name, ".seg"}, seg,                e.seg);
          cmp({e.name, ".ft"},  {7'h0, frame_tick}, {7'h0, e.ft});
        end
        if (e.chk2) begin
          cmp({e.name, ".an2"},  {7'h0, an2},         {7'h0, e.an2});
          cmp({e.name, ".seg2"}, seg2,                e.seg2);
          cmp({e.name, ".ft2"},  {7'h0, frame_tick2}, {7'h0, e.ft2});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    exp_t e;
    rst = 1'b1;
    en  = 1'b0;
    e = mk(4'hF, 8'hFF, 1'b0, "reset");
    e.chk2 = 1'b1;
    step(e);
    rst = 1'b0;
  endtask

  task automatic run_scan(input int n, input string name);
    for (int k = 0; k < n; k++)
      step(mk(AN_TAB[(k/4)%4], SEG_1234[(k/4)%4], (k%16) == 15, name));
  endtask

  initial begin
    exp_t e;
    logic [7:0] s;
    rst = 1'b1; en = 1'b0;
    digits = 16'h0; dp = 4'h0; blink_mask = 4'h0;
    digits2 = 4'h5; dp2 = 1'b0; blink_mask2 = 1'b0;
    @(negedge clk);

    // Basic scan of 1234
    do_reset();
    digits = 16'h1234; en = 1'b1;
    run_scan(36, "scan_1234");

    // Decimal point on digit 2
    do_reset();
    digits = 16'hABCD; dp = 4'b0100; en = 1'b1;
    for (int k = 0; k < 16; k++)
      step(mk(AN_TAB[k/4], SEG_ABCD[k/4], k == 15, "dp_abcd"));
    dp = 4'h0;

    // Blink on digit 0
    do_reset();
    digits = 16'h1234; blink_mask = 4'b0001; en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      s = SEG_1234[(k/4)%4];
`ifdef SEG_SCANNER_BLINK_EN
      if (((k/4)%4) == 0 && ((k/16)%2) == 1) s = 8'hFF;
`endif
      step(mk(AN_TAB[(k/4)%4], s, (k%16) == 15, "blink"));
    end
    blink_mask = 4'h0;

    // Enable dropped at idx=2, ps=1
    do_reset();
    en = 1'b1;
    run_scan(9, "pre_pause");
    en = 1'b0;
    for (int k = 0; k < 10; k++) step(mk(4'hF, 8'hFF, 1'b0, "en_off"));
    en = 1'b1;
    for (int m = 0; m < 3; m++) step(mk(AN_TAB[2], SEG_1234[2], 1'b0, "resume_d2"));
    for (int m = 3; m < 7; m++) step(mk(AN_TAB[3], SEG_1234[3], m == 6, "resume_d3"));
    step(mk(AN_TAB[0], SEG_1234[0], 1'b0, "resume_d0"));

    // Reset pulse while digit 3 is active
    do_reset();
    en = 1'b1;
    run_scan(13, "pre_rst");
    rst = 1'b1;
    step(mk(4'hF, 8'hFF, 1'b0, "rst_mid"));
    rst = 1'b0;
    run_scan(17, "post_rst");

    // Single-digit instance
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      e = mk(4'h0, 8'h00, 1'b0, "single");
      e.chk  = 1'b0;
      e.chk2 = 1'b1;
      e.an2  = 1'b0;
      e.seg2 = 8'h92;
      e.ft2  = (k % 2) == 1;
      step(e);
    end

    en = 1'b0;
    e = mk(4'hF, 8'hFF, 1'b0, "idle");
    e.chk = 1'b0;
    step(e);
    step(e);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
